shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-bit shift controller around the existing 16-bit single-position shifter.
- Accepts a shift request of 0..15 positions in either direction and instantiates one shifter.
- Iterates the shifter one position per clock on a holding register.
- Reports the final value plus a sticky overflow flag with a start/done handshake; sits between the ALU opcode decoder and the ALU result mux.

Parameters:
- AMT_W, 4, width of the shift-amount field; maximum shift = 2^AMT_W - 1 (15).
- DATA_W, 16, datapath width; fixed to match the shifter. Other values are unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request strobe; sampled only in IDLE
- a  input  16  operand; captured when start is accepted
- dir  input  1  0 = shift left, 1 = shift right; same encoding as the shifter sel
- amount  input  AMT_W  number of positions to shift
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse; result and overflow are valid
- result  output  16  shifted value; holds until the next accepted start
- overflow  output  1  sticky; 1 if any 1-bit left bit 15 during a left shift

Behaviour:
- Reset (async, active-high) forces:
  - state = IDLE, busy = 0, done = 0
  - result = 0, overflow = 0, internal count = 0, direction register = 0
- Reset asserted mid-operation aborts immediately. No done pulse follows after reset is released.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start = 1 at an edge captures a into the holding register, dir into the direction register and amount into count, and clears overflow.
  - If amount != 0, next state = SHIFT. If amount == 0, next state = DONE with result = a.
  - start = 0: stay in IDLE; all outputs hold.
- SHIFT, each edge:
  - holding register <= shifter.outShift, with the shifter fed by the holding register and the registered direction.
  - overflow <= overflow | shifter.overflow.
  - count <= count - 1.
  - When count == 1 at the edge, next state = DONE.
- DONE:
  - done = 1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency: start accepted at edge E → done high in the cycle after edge E+N (N = amount). Amount 0 gives done in the cycle after E.
- Throughput: one request per N+2 cycles. Back-to-back start is legal in the first IDLE cycle after DONE.
- start while busy = 1 (SHIFT or DONE) is ignored with no side effect. a, dir and amount may change freely after acceptance.
- Shift semantics, per shifter:
  - Left: zero fills bit 0; bit 15 goes out to overflow.
  - Right: zero fills bit 15; bit 0 is discarded with no flag. Overflow stays 0 for all right shifts.
- result is driven from the holding register continuously. It is updated during SHIFT, and bench checks are made only when done = 1.
- count uses AMT_W bits and never wraps: the SHIFT exit condition is count == 1, and amount 0 bypasses SHIFT.
- start held high continuously: one request is accepted per IDLE visit, so a new request is accepted at every return to IDLE.

Test Plan:
- Reset mid-op:
  - Stimulus: a=16'hFFFF, dir=0, amount=15; assert rst after 5 SHIFT cycles.
  - Required response: busy=0, result=0, overflow=0 at once; no done pulse for 20 cycles.
- Left, no overflow:
  - Stimulus: a=16'h0001, dir=0, amount=4.
  - Required response: done in the cycle after edge E+4; result=16'h0010, overflow=0, busy high for 5 cycles.
- Left, sticky overflow:
  - Stimulus: a=16'hC001, dir=0, amount=3.
  - Required response: result=16'h0008, overflow=1.
  - Variant: a=16'h4000, amount=1 gives result=16'h8000, overflow=0.
- Right shift:
  - Stimulus: a=16'h8003, dir=1, amount=15.
  - Required response: result=16'h0001, overflow=0, done after 15 SHIFT cycles.
- Amount zero, then back-to-back:
  - Stimulus: a=16'hA5A5, amount=0, then start held high into the next IDLE with a=16'h00FF, dir=1, amount=8.
  - Required response: first done in the cycle after edge E, result=16'hA5A5; second done gives result=16'h0000, overflow=0.
- Start ignored while busy:
  - Stimulus: pulse start with a=16'h1234 during SHIFT of a request a=16'h0003, dir=0, amount=2.
  - Required response: result=16'h000C, and no second done pulse follows.

Source files
------------

// File: rtl/shift_sequencer.sv
// ============================================================================
//  Module   : shift_sequencer
//  Brief    : Multi-position shift controller that steps a single-position
//             16-bit shifter once per clock, with a start/done handshake.
//  Revision : 1.0
// ============================================================================
`default_nettype none

// Single-position shifter: sel 0 = left (bit 15 out to overflow), 1 = right.
module shifter16 #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] in_shift,
  input  logic              sel,
  output logic [DATA_W-1:0] out_shift,
  output logic              overflow
);
  always_comb begin
    out_shift = '0;
    overflow  = 1'b0;
    if (!sel) begin
      out_shift = {in_shift[DATA_W-2:0], 1'b0};
      overflow  = in_shift[DATA_W-1];
    end else begin
      out_shift = {1'b0, in_shift[DATA_W-1:1]};
    end
  end
endmodule

module shift_sequencer #(
  parameter int AMT_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic              dir,
  input  logic [AMT_W-1:0]  amount,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] c_one = AMT_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_hold;
  logic              r_dir;
  logic [AMT_W-1:0]  r_count;
  logic              r_ovf;
  logic [DATA_W-1:0] w_shifted;
  logic              w_sh_ovf;
  logic              w_accept;

  shifter16 #(.DATA_W(DATA_W)) u_shifter (
    .in_shift  (r_hold),
    .sel       (r_dir),
    .out_shift (w_shifted),
    .overflow  (w_sh_ovf)
  );

  assign w_accept = (r_state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = (amount != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        busy = 1'b1;
        if (r_count == c_one) w_next = DONE;
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Holding register doubles as the result; it only moves on accept or in SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold  <= '0;
      r_dir   <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_hold  <= a;
      r_dir   <= dir;
      r_count <= amount;
      r_ovf   <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_hold  <= w_shifted;
      r_ovf   <= r_ovf | w_sh_ovf;
      r_count <= r_count - c_one;
    end
  end

  assign result   = r_hold;
  assign overflow = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
//  Module   : tb_shift_sequencer
//  Brief    : Scoreboard bench for shift_sequencer (latency, result, overflow).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shift_sequencer;
  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic        dir;
  logic [3:0]  amount;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    int          lat;
  } exp_t;
  exp_t sb[$];

  shift_sequencer #(.AMT_W(4), .DATA_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .dir      (dir),
    .amount   (amount),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width shift; left overflow = any 1 pushed past bit 15.
  function automatic exp_t model(input logic [15:0] va, input logic vdir, input logic [3:0] n);
    exp_t        e;
    logic [31:0] wide;
    if (!vdir) begin
      wide  = {16'h0, va} << n;
      e.res = wide[15:0];
      e.ovf = |wide[31:16];
    end else begin
      e.res = va >> n;
      e.ovf = 1'b0;
    end
    e.lat = int'(n) + 1;
    return e;
  endfunction

  // Drive one request; returns at the first negedge after the accepting edge.
  task automatic issue(input logic [15:0] va, input logic vdir, input logic [3:0] vamt,
                       input bit track);
    @(negedge clk);
    a = va; dir = vdir; amount = vamt; start = 1'b1;
    if (track) sb.push_back(model(va, vdir, vamt));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, recording latency in cycles after the accept edge.
  task automatic collect(input int k0, output int lat, output int nbusy,
                         output logic [15:0] res, output logic ovf, output bit got);
    lat = k0; nbusy = 0; got = 1'b0; res = 16'h0; ovf = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (busy) nbusy++;
      if (done) begin
        got = 1'b1; res = result; ovf = overflow;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; dir = 1'b0; amount = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 16'h0)   begin errors++; $display("FAIL reset_result got=%h exp=0000", result); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    rst = 1'b0;
  endtask

  task automatic test_reset_midop();
    int seen;
    issue(16'hFFFF, 1'b0, 4'd15, 1'b0);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (result !== 16'h0)  begin errors++; $display("FAIL midrst_result got=%h exp=0000", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf got=%b exp=0", overflow); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_nodone got=%0d pulses exp=0", seen); end
  endtask

  task automatic test_left();
    int lat, nb; logic [15:0] r; logic o; bit got; exp_t e;
    issue(16'h0001, 1'b0, 4'd4, 1'b1);
    collect(1, lat, nb, r, o, got);
    e = sb.pop_front();
    checks++; if (!got)        begin errors++; $display("FAIL left_timeout got=none exp=done"); end
    checks++; if (r !== e.res) begin errors++; $display("FAIL left_result got=%h exp=%h", r, e.res); end
    checks++; if (o !== e.ovf) begin errors++; $display("FAIL left_ovf got=%b exp=%b", o, e.ovf); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL left_latency got=%0d exp=%0d", lat, e.lat); end
    checks++; if (nb != 5)     begin errors++; $display("FAIL left_busy_cycles got=%0d exp=5", nb); end
    checks++; if (r !== 16'h0010) begin errors++; $display("FAIL left_const got=%h exp=0010", r); end
  endtask

  task automatic test_overflow();
    int lat, nb; logic [15:0] r; logic o; bit got; exp_t e;
    issue(16'hC001, 1'b0, 4'd3, 1'b1);
    collect(1, lat, nb, r, o, got);
    e = sb.pop_front();
    checks++; if (!got || r !== 16'h0008) begin errors++; $display("FAIL ovf_result got=%h exp=0008", r); end
    checks++; if (o !== 1'b1)             begin errors++; $display("FAIL ovf_sticky got=%b exp=1", o); end
    checks++; if (lat != e.lat)           begin errors++; $display("FAIL ovf_latency got=%0d exp=%0d", lat, e.lat); end
    @(negedge clk);
    issue(16'h4000, 1'b0, 4'd1, 1'b1);
    collect(1, lat, nb, r, o, got);
    e = sb.pop_front();
    checks++; if (!got || r !== 16'h8000) begin errors++; $display("FAIL ovf_edge_result got=%h exp=8000", r); end
    checks++; if (o !== 1'b0)             begin errors++; $display("FAIL ovf_edge_flag got=%b exp=0", o); end
    checks++; if (lat != e.lat)           begin errors++; $display("FAIL ovf_edge_latency got=%0d exp=%0d", lat, e.lat); end
  endtask

  task automatic test_right();
    int lat, nb; logic [15:0] r; logic o; bit got; exp_t e;
    issue(16'h8003, 1'b1, 4'd15, 1'b1);
    collect(1, lat, nb, r, o, got);
    e = sb.pop_front();
    checks++; if (!got || r !== 16'h0001) begin errors++; $display("FAIL right_result got=%h exp=0001", r); end
    checks++; if (o !== 1'b0)             begin errors++; $display("FAIL right_ovf got=%b exp=0", o); end
    checks++; if (lat != 16)              begin errors++; $display("FAIL right_latency got=%0d exp=16", lat); end
  endtask

  task automatic test_back_to_back();
    int lat, nb; logic [15:0] r; logic o; bit got; exp_t e;
    @(negedge clk);
    a = 16'hA5A5; dir = 1'b0; amount = 4'd0; start = 1'b1;
    sb.push_back(model(16'hA5A5, 1'b0, 4'd0));
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (done !== 1'b1)   begin errors++; $display("FAIL b2b_first_done got=%b exp=1", done); end
    checks++; if (result !== e.res) begin errors++; $display("FAIL b2b_first_result got=%h exp=%h", result, e.res); end
    a = 16'h00FF; dir = 1'b1; amount = 4'd8;
    sb.push_back(model(16'h00FF, 1'b1, 4'd8));
    @(negedge clk);
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
    @(negedge clk);
    start = 1'b0;
    collect(1, lat, nb, r, o, got);
    e = sb.pop_front();
    checks++; if (!got || r !== 16'h0000) begin errors++; $display("FAIL b2b_second_result got=%h exp=0000", r); end
    checks++; if (o !== 1'b0)             begin errors++; $display("FAIL b2b_second_ovf got=%b exp=0", o); end
    checks++; if (lat != e.lat)           begin errors++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, e.lat); end
  endtask

  task automatic test_ignore_busy();
    int lat, nb, seen; logic [15:0] r; logic o; bit got; exp_t e;
    issue(16'h0003, 1'b0, 4'd2, 1'b1);
    a = 16'h1234; amount = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(2, lat, nb, r, o, got);
    e = sb.pop_front();
    checks++; if (!got || r !== 16'h000C) begin errors++; $display("FAIL ignore_result got=%h exp=000C", r); end
    checks++; if (lat != e.lat)           begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, e.lat); end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL ignore_extra_done got=%0d exp=0", seen); end
  endtask

  task automatic test_random();
    int lat, nb; logic [15:0] r; logic o; bit got; exp_t e;
    logic [15:0] va; logic vd; logic [3:0] vn;
    for (int i = 0; i < 8; i++) begin
      va = 16'($urandom);
      vd = 1'($urandom_range(0, 1));
      vn = 4'($urandom_range(0, 15));
      issue(va, vd, vn, 1'b1);
      collect(1, lat, nb, r, o, got);
      e = sb.pop_front();
      checks++;
      if (!got || r !== e.res || o !== e.ovf || lat != e.lat) begin
        errors++;
        $display("FAIL rand_%0d a=%h dir=%b n=%0d got res=%h ovf=%b lat=%0d exp res=%h ovf=%b lat=%0d",
                 i, va, vd, vn, r, o, lat, e.res, e.ovf, e.lat);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_reset_midop();
    test_left();
    @(negedge clk);
    test_overflow();
    @(negedge clk);
    test_right();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_ignore_busy();
    test_random();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
